bigmul_comba_unit: RTL and testbench

Parametrised product-scanning (Comba) big-integer multiplier. It computes R = A × B for operands of 1..NWORDS words of W bits. LANES partial products are issued per cycle along each diagonal, and a wide carry-save-free accumulator retires one result word per diagonal. It sits beside the core as a memory-mapped accelerator: software fills the A/B word memories, pulses start, waits for done, then reads R through a registered read port.

---
 rtl/bigmul_comba_if.sv | 40 ++++
 rtl/bigmul_comba_unit.sv | 140 ++++++++++++++
 tb/tb_bigmul_comba_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bigmul_comba_if.sv
// Bus bundle for the Comba big-integer multiplier: control, A/B write ports, R read port.
// The sq signal exists only when BIGMUL_SQR_EN is defined.
interface bigmul_comba_if #(
  parameter int W      = 64,
  parameter int NWORDS = 64,
  parameter int AW     = $clog2(NWORDS)
);
  logic          start;
  logic [AW:0]   op_len;
`ifdef BIGMUL_SQR_EN
  logic          sq;
`endif
  logic          busy;
  logic          done;
  logic          err;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [W-1:0]  a_wdata;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [W-1:0]  b_wdata;
  logic [AW:0]   r_addr;
  logic [W-1:0]  r_data;

  modport master (
    output start, op_len, a_we, a_addr, a_wdata, b_we, b_addr, b_wdata, r_addr,
    input  busy, done, err, r_data
`ifdef BIGMUL_SQR_EN
    , output sq
`endif
  );

  modport slave (
    input  start, op_len, a_we, a_addr, a_wdata, b_we, b_addr, b_wdata, r_addr,
    output busy, done, err, r_data
`ifdef BIGMUL_SQR_EN
    , input sq
`endif
  );
endinterface

// File: rtl/bigmul_comba_unit.sv
// Product-scanning (Comba) multiplier R = A*B, LANES partial products per cycle per diagonal.
// Optional square mode (B taken from A memory) enabled by defining BIGMUL_SQR_EN.
module bigmul_comba_unit #(
  parameter int W      = 64,
  parameter int NWORDS = 64,
  parameter int LANES  = 4,
  parameter int AW     = $clog2(NWORDS)
) (
  input logic          clk,
  input logic          rstn,
  bigmul_comba_if.slave bus
);
  localparam int ACC_W = 2*W + AW + 2;
  localparam int IW    = AW + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic             busy_r, done_r, err_r;
  logic [W-1:0]     r_data_r;
  logic [AW:0]      n_r;
  logic [IW-1:0]    s_r, i_r;
  logic [ACC_W-1:0] acc;
`ifdef BIGMUL_SQR_EN
  logic             sq_r;
`endif

  logic [W-1:0] a_mem [NWORDS];
  logic [W-1:0] b_mem [NWORDS];
  logic [W-1:0] r_mem [2*NWORDS];

  logic [IW-1:0]    n_ext, imax, imin_next;
  logic             last_batch, last_diag, len_ok;
  logic [ACC_W-1:0] batch, sum;
  logic [AW:0]      s_idx;

  assign n_ext      = IW'(n_r);
  assign imax       = (s_r < n_ext) ? s_r : n_ext - IW'(1);
  assign imin_next  = (s_r + IW'(2) > n_ext) ? s_r + IW'(2) - n_ext : '0;
  assign last_batch = (i_r + IW'(LANES)) > imax;
  assign last_diag  = s_r == (n_ext << 1) - IW'(2);
  assign len_ok     = (bus.op_len != '0) && ({1'b0, bus.op_len} <= (AW+2)'(NWORDS));
  assign s_idx      = s_r[AW:0];
  assign sum        = acc + batch;

  // Lanes beyond imax are masked, so their (possibly wrapped) addresses are harmless.
  always_comb begin
    logic [IW-1:0]  k;
    logic [AW-1:0]  j;
    logic [W-1:0]   b_w;
    logic [2*W-1:0] p;
    batch = '0;
    k     = '0;
    j     = '0;
    b_w   = '0;
    p     = '0;
    for (int l = 0; l < LANES; l++) begin
      k = i_r + IW'(l);
      j = AW'(s_r - k);
`ifdef BIGMUL_SQR_EN
      b_w = sq_r ? a_mem[j] : b_mem[j];
`else
      b_w = b_mem[j];
`endif
      p = (2*W)'(a_mem[k[AW-1:0]]) * (2*W)'(b_w);
      if (k <= imax) batch = batch + ACC_W'(p);
    end
  end

  always_ff @(posedge clk) begin
    if (bus.a_we && !busy_r) a_mem[bus.a_addr] <= bus.a_wdata;
    if (bus.b_we && !busy_r) b_mem[bus.b_addr] <= bus.b_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      r_data_r <= '0;
      n_r      <= '0;
      s_r      <= '0;
      i_r      <= '0;
      acc      <= '0;
`ifdef BIGMUL_SQR_EN
      sq_r     <= 1'b0;
`endif
      for (int m = 0; m < 2*NWORDS; m++) r_mem[m] <= '0;
    end else begin
      done_r   <= 1'b0;
      r_data_r <= ({1'b0, bus.r_addr} < (AW+2)'(2*NWORDS)) ? r_mem[bus.r_addr] : '0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (len_ok) begin
              state  <= RUN;
              busy_r <= 1'b1;
              err_r  <= 1'b0;
              n_r    <= bus.op_len;
              s_r    <= '0;
              i_r    <= '0;
              acc    <= '0;
`ifdef BIGMUL_SQR_EN
              sq_r   <= bus.sq;
`endif
              for (int m = 0; m < 2*NWORDS; m++) r_mem[m] <= '0;
            end else begin
              err_r  <= 1'b1;
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= sum;
          i_r <= i_r + IW'(LANES);
          if (last_batch) begin
            r_mem[s_idx] <= sum[W-1:0];
            acc          <= sum >> W;
            if (last_diag) begin
              r_mem[s_idx + (AW+1)'(1)] <= sum[2*W-1:W];
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              s_r <= s_r + IW'(1);
              i_r <= imin_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;
  assign bus.r_data = r_data_r;
endmodule

// File: tb/tb_bigmul_comba_unit.sv
// Directed bench for bigmul_comba_unit: operand-scanning reference product plus a cycle-count timing model.
module tb_bigmul_comba_unit;
  localparam int W = 64, NWORDS = 64, LANES = 4, AW = 6;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] FE   = {{(W-1){1'b1}}, 1'b0};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bigmul_comba_if #(.W(W), .NWORDS(NWORDS), .AW(AW)) bus();
  bigmul_comba_unit #(.W(W), .NWORDS(NWORDS), .LANES(LANES), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0, errors = 0;
  logic [W-1:0] a_m [NWORDS];
  logic [W-1:0] b_m [NWORDS];
  logic [W-1:0] r_exp [2*NWORDS];
  logic m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int   m_cnt = 0;

  function automatic int calc_c(int n);
    int c = 0;
    for (int s = 0; s <= 2*n-2; s++) begin
      int lo = (s-n+1 > 0) ? s-n+1 : 0;
      int hi = (s < n-1) ? s : n-1;
      c += (hi - lo + 1 + LANES - 1) / LANES;
    end
    return c;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference product by schoolbook operand scanning.
  task automatic model_mul(int n, bit sq);
    logic [127:0] t, carry;
    logic [W-1:0] bw;
    for (int q = 0; q < 2*NWORDS; q++) r_exp[q] = '0;
    for (int x = 0; x < n; x++) begin
      carry = '0;
      for (int y = 0; y < n; y++) begin
        bw = sq ? a_m[y] : b_m[y];
        t = 128'(r_exp[x+y]) + 128'(a_m[x]) * 128'(bw) + carry;
        r_exp[x+y] = t[W-1:0];
        carry = {64'd0, t[127:64]};
      end
      r_exp[x+n] = carry[W-1:0];
    end
  endtask

  // Timing model: busy for C cycles after an accepted start, then a one-cycle done.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin m_busy = 1'b0; m_done = 1'b1; end
      end else if (bus.start) begin
        if (bus.op_len >= 1 && int'(bus.op_len) <= NWORDS) begin
          m_busy = 1'b1; m_err = 1'b0; m_cnt = calc_c(int'(bus.op_len));
        end else begin
          m_err = 1'b1; m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("busy", 128'(bus.busy), 128'(m_busy));
      chk("done", 128'(bus.done), 128'(m_done));
      chk("err",  128'(bus.err),  128'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(bit is_b, int addr, logic [W-1:0] d);
    if (is_b) begin
      bus.b_we = 1'b1; bus.b_addr = AW'(addr); bus.b_wdata = d; b_m[addr] = d;
    end else begin
      bus.a_we = 1'b1; bus.a_addr = AW'(addr); bus.a_wdata = d; a_m[addr] = d;
    end
    tick();
    bus.a_we = 1'b0; bus.b_we = 1'b0;
  endtask

  task automatic rd(int addr, output logic [W-1:0] d);
    bus.r_addr = (AW+1)'(addr);
    tick();
    d = bus.r_data;
  endtask

  task automatic rd_chk(string name, int addr, logic [W-1:0] exp);
    logic [W-1:0] d;
    rd(addr, d);
    chk(name, 128'(d), 128'(exp));
  endtask

  task automatic check_all(string nm);
    logic [W-1:0] d;
    for (int q = 0; q < 2*NWORDS; q++) begin
      rd(q, d);
      chk($sformatf("%s[%0d]", nm, q), 128'(d), 128'(r_exp[q]));
    end
  endtask

  task automatic run(int n, bit sq);
    int  cyc;
    bit  legal = (n >= 1 && n <= NWORDS);
    bus.op_len = (AW+1)'(n);
`ifdef BIGMUL_SQR_EN
    bus.sq = sq;
`endif
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 5000) begin tick(); cyc++; end
    chk($sformatf("done_latency_n%0d", n), 128'(cyc), 128'(legal ? calc_c(n) + 1 : 1));
    if (legal) model_mul(n, sq);
  endtask

  initial begin
    bus.start = 0; bus.op_len = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.r_addr = 0;
`ifdef BIGMUL_SQR_EN
    bus.sq = 0;
`endif
    for (int q = 0; q < 2*NWORDS; q++) r_exp[q] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_err",  128'(bus.err),  128'(0));
    chk("rst_rdata", 128'(bus.r_data), 128'(0));
    rstn = 1'b1;
    check_all("rst_r");

    // n=1, all-ones
    wr(0, 0, ONES); wr(1, 0, ONES);
    run(1, 0);
    chk("model_n1_r1", 128'(r_exp[1]), 128'(FE));
    rd_chk("n1_r0", 0, 64'd1);
    rd_chk("n1_r1", 1, FE);
    check_all("n1");

    // n=2, all-ones
    wr(0, 1, ONES); wr(1, 1, ONES);
    run(2, 0);
    rd_chk("n2_r0", 0, 64'd1);
    rd_chk("n2_r1", 1, 64'd0);
    rd_chk("n2_r2", 2, FE);
    rd_chk("n2_r3", 3, ONES);
    check_all("n2");

    // n=64, all-ones carry stress
    for (int q = 0; q < NWORDS; q++) begin wr(0, q, ONES); wr(1, q, ONES); end
    run(64, 0);
    chk("model_n64_r64", 128'(r_exp[64]), 128'(FE));
    rd_chk("n64_r0", 0, 64'd1);
    rd_chk("n64_r63", 63, 64'd0);
    rd_chk("n64_r64", 64, FE);
    rd_chk("n64_r127", 127, ONES);
    check_all("n64");

    // n=64 random operands
    for (int q = 0; q < NWORDS; q++) begin
      wr(0, q, {$urandom, $urandom}); wr(1, q, {$urandom, $urandom});
    end
    run(64, 0);
    check_all("rnd64");

    // illegal lengths leave R untouched
    run(0, 0);
    chk("err_len0", 128'(bus.err), 128'(1));
    check_all("len0_r");
    run(65, 0);
    chk("err_len65", 128'(bus.err), 128'(1));
    check_all("len65_r");
    wr(0, 0, 64'd7); wr(1, 0, 64'd6);
    run(1, 0);
    chk("err_cleared", 128'(bus.err), 128'(0));
    rd_chk("n1_42", 0, 64'd42);
    check_all("after_err");

    // reset in the middle of a long run
    bus.op_len = (AW+1)'(64);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (40) tick();
    #2 rstn = 1'b0;
    #1;
    chk("midrst_busy", 128'(bus.busy), 128'(0));
    chk("midrst_done", 128'(bus.done), 128'(0));
    chk("midrst_rdata", 128'(bus.r_data), 128'(0));
    tick();
    rstn = 1'b1;
    for (int q = 0; q < 2*NWORDS; q++) r_exp[q] = '0;
    check_all("midrst_r");

    // n=3 small integers
    wr(0, 0, 64'd1); wr(0, 1, 64'd2); wr(0, 2, 64'd3);
    wr(1, 0, 64'd4); wr(1, 1, 64'd5); wr(1, 2, 64'd6);
    run(3, 0);
    rd_chk("n3_r0", 0, 64'd4);
    rd_chk("n3_r1", 1, 64'd13);
    rd_chk("n3_r2", 2, 64'd28);
    rd_chk("n3_r3", 3, 64'd27);
    rd_chk("n3_r4", 4, 64'd18);
    rd_chk("n3_r5", 5, 64'd0);
    check_all("n3");

`ifdef BIGMUL_SQR_EN
    wr(0, 0, 64'd3); wr(1, 0, 64'd5);
    run(1, 1);
    rd_chk("sq_r0", 0, 64'd9);
    rd_chk("sq_r1", 1, 64'd0);
    run(1, 0);
    rd_chk("nosq_r0", 0, 64'd15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
